ram64_arbiter: RTL and testbench
================================

RAM64_ARBITER -- requirements
Module: ram64_arbiter

Interface
REQ-001 Parameter CLEAR_ON_RESET, default 1, meaning: 1 = zero-fill all 64 RAM words after every reset release; 0 = skip the fill.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester n has a pending access.
REQ-005 req0_we, req1_we  input  1 each  1 = write, 0 = read.
REQ-006 req0_addr, req1_addr  input  6 each  word address.
REQ-007 req0_wdata, req1_wdata  input  16 each  write data.
REQ-008 req0_ready, req1_ready  output  1 each  grant; access accepted on a cycle with valid and ready both high.
REQ-009 rsp0_valid, rsp1_valid  output  1 each  one-cycle read-data strobe for requester n.
REQ-010 rsp_rdata  output  16  read data; valid only while some rsp_valid is high.
REQ-011 mem_addr  output  6, mem_data_in  output  16, mem_we  output  1  drive the shared 64x16 RAM.
REQ-012 mem_data_out  input  16  RAM read data.
REQ-013 busy  output  1  high while the zero-fill runs.

Function
REQ-014 The block SHALL have three states: CLEAR, IDLE, RD_WAIT.
REQ-015 On reset release the block SHALL enter CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
REQ-016 In CLEAR, a 6-bit counter runs from 0 to 63, one word per cycle; the block SHALL drive mem_we=1, mem_addr=counter, mem_data_in=0, busy=1, and both ready outputs 0.
REQ-017 After the write to address 63 the block SHALL go to IDLE and drop busy; total fill = exactly 64 cycles.
REQ-018 In IDLE, ready SHALL go to at most one requester per cycle, combinationally from the valid inputs and the last_grant register.
REQ-019 With one valid requester, that requester SHALL get ready.
REQ-020 With both valid, the requester not in last_grant SHALL get ready.
REQ-021 last_grant SHALL update to the accepted requester on every accepted access; reset value = 1, so requester 0 wins the first tie.
REQ-022 An accepted write SHALL drive mem_we=1, mem_addr=reqN_addr, mem_data_in=reqN_wdata in the same cycle, and the FSM SHALL stay in IDLE; back-to-back writes are allowed every cycle.
REQ-023 An accepted read (cycle T) SHALL drive mem_we=0, mem_addr=reqN_addr, and the FSM SHALL go to RD_WAIT.
REQ-024 In RD_WAIT (cycle T+1) the block SHALL hold mem_addr, keep mem_we=0 and both ready outputs 0, and capture mem_data_out into rsp_rdata at the end of the cycle.
REQ-025 The block SHALL then return to IDLE, with rspN_valid=1 for exactly cycle T+2.
REQ-026 In cycle T+2 a new grant SHALL be allowed.
REQ-027 In IDLE with no grant, the block SHALL drive mem_we=0, mem_addr=0, mem_data_in=0.
REQ-028 Requests arriving during CLEAR or RD_WAIT SHALL wait; the requester holds valid and its fields stable until ready.
REQ-029 rsp_rdata SHALL hold its last value when no rsp_valid is high.

Reset
REQ-030 While reset is high, all outputs SHALL be 0: mem_we, mem_addr, mem_data_in, ready, rsp_valid, rsp_rdata.
REQ-031 While reset is high, busy SHALL equal CLEAR_ON_RESET.
REQ-032 Reset SHALL set the clear counter to 0 and last_grant to 1.
REQ-033 Reset during CLEAR SHALL restart the fill from address 0.
REQ-034 Reset during RD_WAIT SHALL discard the pending read; no rsp_valid is issued.

Verification
REQ-035 Reset with CLEAR_ON_RESET=1 -> busy high 64 cycles; mem_we high for addresses 0..63 with data 0x0000; a later read of address 5 returns 0x0000.
REQ-036 Req0 writes address 0 = 0xAAAA, then reads address 0 -> rsp0_valid exactly 2 cycles after the read grant with rsp_rdata = 0xAAAA; rsp1_valid stays 0.
REQ-037 Req0 (write address 1 = 0xF0F0) and req1 (write address 63 = 0x5555) assert together -> req0 granted first cycle, req1 next; read-backs return 0xF0F0 and 0x5555.
REQ-038 Both requesters continuously valid with reads -> grants alternate 0,1,0,1; each read response arrives 2 cycles after its grant; no grants during RD_WAIT.
REQ-039 Req1 valid throughout CLEAR -> req1_ready stays 0 until the cycle busy drops, then is granted.
REQ-040 Reset asserted in RD_WAIT -> no rsp_valid; after release, busy rises and the fill restarts at mem_addr 0.

Source files
------------

// File: rtl/ram64_arbiter.sv
// Two-requester round-robin arbiter for a shared 64x16 single-port synchronous RAM,
// with an optional zero-fill of the whole RAM after every reset release.
module ram64_arbiter #(
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_we,
    input  logic [5:0]  req0_addr,
    input  logic [15:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_we,
    input  logic [5:0]  req1_addr,
    input  logic [15:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_rdata,
    output logic [5:0]  mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_we,
    input  logic [15:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {StClear, StIdle, StRdWait} state_e;

    localparam state_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [5:0]  rd_addr_q, rd_addr_d;
    logic        rd_id_q, rd_id_d;
    logic        rsp0_q, rsp0_d;
    logic        rsp1_q, rsp1_d;
    logic [15:0] rdata_q, rdata_d;

    logic        grant0, grant1;
    logic        sel_we;
    logic [5:0]  sel_addr;
    logic [15:0] sel_wdata;

    // last_q = 1 means requester 1 won last, so requester 0 takes a tie.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == StIdle && !reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        sel_we    = grant1 ? req1_we    : req0_we;
        sel_addr  = grant1 ? req1_addr  : req0_addr;
        sel_wdata = grant1 ? req1_wdata : req0_wdata;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rd_addr_d   = rd_addr_q;
        rd_id_d     = rd_id_q;
        rsp0_d      = 1'b0;
        rsp1_d      = 1'b0;
        rdata_d     = rdata_q;
        mem_we      = 1'b0;
        mem_addr    = 6'd0;
        mem_data_in = 16'd0;
        unique case (state_q)
            StClear: begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd63) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (grant0 || grant1) begin
                    last_d   = grant1;
                    mem_addr = sel_addr;
                    if (sel_we) begin
                        mem_we      = 1'b1;
                        mem_data_in = sel_wdata;
                    end else begin
                        rd_addr_d = sel_addr;
                        rd_id_d   = grant1;
                        state_d   = StRdWait;
                    end
                end
            end
            StRdWait: begin
                // RAM output is valid this cycle for the address presented last cycle.
                mem_addr = rd_addr_q;
                rdata_d  = mem_data_out;
                rsp0_d   = !rd_id_q;
                rsp1_d   = rd_id_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (reset) begin
            mem_we      = 1'b0;
            mem_addr    = 6'd0;
            mem_data_in = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ResetState;
            cnt_q     <= 6'd0;
            last_q    <= 1'b1;
            rd_addr_q <= 6'd0;
            rd_id_q   <= 1'b0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rdata_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            rd_id_q   <= rd_id_d;
            rsp0_q    <= rsp0_d;
            rsp1_q    <= rsp1_d;
            rdata_q   <= rdata_d;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign rsp0_valid = rsp0_q;
    assign rsp1_valid = rsp1_q;
    assign rsp_rdata  = rdata_q;
    assign busy       = (state_q == StClear);

endmodule

// File: tb/tb_ram64_arbiter.sv
// Randomized bench for ram64_arbiter: a cycle-level transaction model predicts grants,
// RAM drive, fill progress and read responses; a behavioural RAM sits behind the DUT.
module tb_ram64_arbiter;

    localparam bit CLR = 1'b1;

    typedef struct packed {
        logic        we;
        logic [5:0]  addr;
        logic [15:0] wdata;
    } txn_t;

    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, mem_we, busy;
    logic [15:0] rsp_rdata, mem_data_in;
    logic [15:0] mem_data_out = 16'd0;
    logic [5:0]  mem_addr;

    bit          v[2];
    txn_t        t[2];
    txn_t        q0[$];
    txn_t        q1[$];
    rsp_t        rq[$];
    logic [15:0] ram[64];
    logic [15:0] ram_model[64];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          clear_left = 0;
    int          stall = 0;
    int          last = 1;
    int          g = -1;
    bit          in_rst = 1'b1;
    bit          rnd_en = 1'b0;
    logic [5:0]  rd_addr = 6'd0;
    logic [15:0] exp_rdata = 16'd0;

    always #5 clk = ~clk;

    ram64_arbiter #(.CLEAR_ON_RESET(CLR)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (v[0]),
        .req0_we      (t[0].we),
        .req0_addr    (t[0].addr),
        .req0_wdata   (t[0].wdata),
        .req0_ready   (req0_ready),
        .req1_valid   (v[1]),
        .req1_we      (t[1].we),
        .req1_addr    (t[1].addr),
        .req1_wdata   (t[1].wdata),
        .req1_ready   (req1_ready),
        .rsp0_valid   (rsp0_valid),
        .rsp1_valid   (rsp1_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_we       (mem_we),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    // Shared RAM: synchronous, read-before-write.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data_in;
        mem_data_out <= ram[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t x;
        x.we    = 1'($urandom_range(0, 1));
        x.addr  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 7));
        x.wdata = 16'($urandom);
        return x;
    endfunction

    function automatic txn_t mk(input logic we, input logic [5:0] a, input logic [15:0] d);
        txn_t x;
        x.we    = we;
        x.addr  = a;
        x.wdata = d;
        return x;
    endfunction

    task automatic fetch(input int i);
        if (i == 0 && q0.size() > 0) begin
            t[0] = q0.pop_front();
            v[0] = 1'b1;
        end else if (i == 1 && q1.size() > 0) begin
            t[1] = q1.pop_front();
            v[1] = 1'b1;
        end else if (rnd_en && $urandom_range(0, 2) != 0) begin
            t[i] = rand_txn();
            v[i] = 1'b1;
        end
    endtask

    task automatic step();
        logic        e_r0, e_r1, e_we, e_busy, e_v0, e_v1, chk_din;
        logic [5:0]  e_addr;
        logic [15:0] e_din;
        @(negedge clk);
        g       = -1;
        e_we    = 1'b0;
        e_addr  = 6'd0;
        e_din   = 16'd0;
        e_busy  = 1'b0;
        chk_din = 1'b1;
        if (in_rst) begin
            e_busy = CLR;
        end else if (clear_left > 0) begin
            e_busy = 1'b1;
            e_we   = 1'b1;
            e_addr = 6'(64 - clear_left);
        end else if (stall > 0) begin
            e_addr  = rd_addr;
            chk_din = 1'b0;
        end else begin
            if (v[0] && v[1]) g = (last == 1) ? 0 : 1;
            else if (v[0]) g = 0;
            else if (v[1]) g = 1;
            if (g >= 0) begin
                e_addr = t[g].addr;
                if (t[g].we) begin
                    e_we  = 1'b1;
                    e_din = t[g].wdata;
                end
            end
        end
        e_r0 = (g == 0);
        e_r1 = (g == 1);
        e_v0 = 1'b0;
        e_v1 = 1'b0;
        if (!in_rst && rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].id == 0) e_v0 = 1'b1;
            else e_v1 = 1'b1;
            exp_rdata = rq[0].data;
            void'(rq.pop_front());
        end
        check_eq("req0_ready", 32'(req0_ready), 32'(e_r0));
        check_eq("req1_ready", 32'(req1_ready), 32'(e_r1));
        check_eq("mem_we", 32'(mem_we), 32'(e_we));
        check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
        if (chk_din) check_eq("mem_data_in", 32'(mem_data_in), 32'(e_din));
        check_eq("busy", 32'(busy), 32'(e_busy));
        check_eq("rsp0_valid", 32'(rsp0_valid), 32'(e_v0));
        check_eq("rsp1_valid", 32'(rsp1_valid), 32'(e_v1));
        check_eq("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
        @(posedge clk);
        cyc++;
        if (!in_rst) begin
            if (clear_left > 0) begin
                ram_model[64 - clear_left] = 16'd0;
                clear_left--;
            end else if (stall > 0) begin
                stall--;
            end else if (g >= 0) begin
                last = g;
                if (t[g].we) begin
                    ram_model[t[g].addr] = t[g].wdata;
                end else begin
                    stall   = 1;
                    rd_addr = t[g].addr;
                    rq.push_back('{cyc + 1, g, ram_model[t[g].addr]});
                end
            end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (g == i) v[i] = 1'b0;
            if (!v[i]) fetch(i);
        end
    endtask

    task automatic assert_reset();
        reset      = 1'b1;
        in_rst     = 1'b1;
        clear_left = 0;
        stall      = 0;
        last       = 1;
        exp_rdata  = 16'd0;
        rq.delete();
    endtask

    task automatic release_reset();
        reset      = 1'b0;
        in_rst     = 1'b0;
        clear_left = CLR ? 64 : 0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = 16'($urandom);
        v[0] = 1'b0;
        v[1] = 1'b0;
        t[0] = '0;
        t[1] = '0;
        assert_reset();
        // Requester 1 waits through the fill, then reads a cleared word.
        q1.push_back(mk(1'b0, 6'd5, 16'h0));
        step();
        step();
        release_reset();
        repeat (70) step();

        q0.push_back(mk(1'b1, 6'd1, 16'hF0F0));
        q0.push_back(mk(1'b0, 6'd1, 16'h0));
        q1.push_back(mk(1'b1, 6'd63, 16'h5555));
        q1.push_back(mk(1'b0, 6'd63, 16'h0));
        repeat (12) step();

        q0.push_back(mk(1'b1, 6'd0, 16'hAAAA));
        q0.push_back(mk(1'b0, 6'd0, 16'h0));
        repeat (10) step();

        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'b0, 6'(i), 16'h0));
            q1.push_back(mk(1'b0, 6'(60 + i), 16'h0));
        end
        repeat (24) step();

        rnd_en = 1'b1;
        repeat (2000) step();
        rnd_en = 1'b0;
        repeat (12) step();

        // Reset while a read is waiting on the RAM: its response must never appear.
        begin
            bit reached;
            reached = 1'b0;
            q0.push_back(mk(1'b0, 6'd1, 16'h0));
            for (int n = 0; n < 20 && !reached; n++) begin
                step();
                if (stall > 0) reached = 1'b1;
            end
            check_eq("rdwait_reached", 32'(reached), 32'd1);
        end
        assert_reset();
        repeat (3) step();
        release_reset();
        repeat (66) step();
        rnd_en = 1'b1;
        repeat (200) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
